timn_apb_top: RTL



---
 rtl/timn_pkg.sv | 32 +++
 rtl/timn_channel.sv | 98 +++++++++
 rtl/timn_apb_top.sv | 92 +++++++++
 3 files changed

// File: rtl/timn_pkg.sv
// Shared definitions for the N-channel APB timer: register map, CTRL bit layout, counting modes.
package timn_pkg;

  localparam logic [11:0] CH_STRIDE = 12'h014;

  localparam logic [11:0] OFF_LOAD  = 12'h000;
  localparam logic [11:0] OFF_CUR   = 12'h004;
  localparam logic [11:0] OFF_CTRL  = 12'h008;
  localparam logic [11:0] OFF_EOI   = 12'h00C;
  localparam logic [11:0] OFF_ISTAT = 12'h010;

  localparam logic [11:0] GLB_ISTAT_ALL = 12'h0A0;
  localparam logic [11:0] GLB_EOI_ALL   = 12'h0A4;
  localparam logic [11:0] GLB_RAW_ALL   = 12'h0A8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE    = 1;
  localparam int CTRL_IMASK   = 2;
  localparam int CTRL_ONESHOT = 3;
  localparam int CTRL_W       = 4;

  typedef enum logic {
    MODE_FREE = 1'b0,
    MODE_USER = 1'b1
  } timn_mode_e;

  // Byte address of a per-channel register; channel index never exceeds 8 so 12 bits suffice.
  function automatic logic [11:0] ch_addr(input int ch, input logic [11:0] off);
    return 12'(ch) * CH_STRIDE + off;
  endfunction

endpackage

// File: rtl/timn_channel.sv
// One timer channel: LOAD/CTRL/CUR registers, down-counting with reload, raw interrupt and trigger pulse.
module timn_channel
  import timn_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_we_i,
  input  logic [CNT_W-1:0]  load_wdata_i,
  input  logic              ctrl_we_i,
  input  logic [CTRL_W-1:0] ctrl_wdata_i,
  input  logic              eoi_clr_i,
  input  logic              etb_on_i,
  input  logic              etb_off_i,
  output logic [CNT_W-1:0]  load_o,
  output logic [CNT_W-1:0]  cur_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              raw_o,
  output logic              trig_o
);

  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic             en_q, en_d;
  timn_mode_e       mode_q, mode_d;
  logic             imask_q, imask_d;
  logic             oneshot_q, oneshot_d;
  logic             pend_q, pend_d;
  logic             raw_q, raw_d;
  logic             trig_q, trig_d;
  logic             expire;

  // pend_q marks the cycle after EN rose: CUR takes LOAD then, and expiry is not evaluated on stale CUR.
  always_comb begin
    expire    = en_q && !pend_q && (cur_q == '0);
    load_d    = load_we_i ? load_wdata_i : load_q;
    mode_d    = mode_q;
    imask_d   = imask_q;
    oneshot_d = oneshot_q;
    if (ctrl_we_i) begin
      mode_d    = timn_mode_e'(ctrl_wdata_i[CTRL_MODE]);
      imask_d   = ctrl_wdata_i[CTRL_IMASK];
      oneshot_d = ctrl_wdata_i[CTRL_ONESHOT];
    end

    en_d = en_q;
    if (etb_off_i)                en_d = 1'b0;
    else if (etb_on_i)            en_d = 1'b1;
    else if (ctrl_we_i)           en_d = ctrl_wdata_i[CTRL_EN];
    else if (expire && oneshot_q) en_d = 1'b0;
    pend_d = !en_q && en_d;

    if (pend_q)              cur_d = load_q;
    else if (expire) begin
      if (oneshot_q)                 cur_d = '0;
      else if (mode_q == MODE_USER)  cur_d = load_q;
      else                           cur_d = '1;
    end
    else if (en_q)           cur_d = cur_q - CNT_W'(1);
    else                     cur_d = cur_q;

    // A coincident expiry beats an EOI clear.
    raw_d  = expire | (raw_q & ~eoi_clr_i);
    trig_d = expire;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_q    <= '0;
      cur_q     <= '0;
      en_q      <= 1'b0;
      mode_q    <= MODE_FREE;
      imask_q   <= 1'b0;
      oneshot_q <= 1'b0;
      pend_q    <= 1'b0;
      raw_q     <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      load_q    <= load_d;
      cur_q     <= cur_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      imask_q   <= imask_d;
      oneshot_q <= oneshot_d;
      pend_q    <= pend_d;
      raw_q     <= raw_d;
      trig_q    <= trig_d;
    end
  end

  assign load_o = load_q;
  assign cur_o  = cur_q;
  assign ctrl_o = {oneshot_q, imask_q, mode_q, en_q};
  assign raw_o  = raw_q;
  assign trig_o = trig_q;

endmodule

// File: rtl/timn_apb_top.sv
// APB timer block top: address decode, read mux, global status registers, NUM_CH channels.
// Optional build macro TIMN_SEC_CHK_EN blocks non-secure accesses when tipc_trust is set.
module timn_apb_top
  import timn_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [11:0]       paddr,
  input  logic [31:0]       pwdata,
  input  logic [2:0]        pprot,
  input  logic              tipc_trust,
  output logic [31:0]       prdata,
  input  logic [NUM_CH-1:0] etb_trig_en_on,
  input  logic [NUM_CH-1:0] etb_trig_en_off,
  output logic [NUM_CH-1:0] etb_trig,
  output logic [NUM_CH-1:0] intr
);

  logic [11:0]       addr;
  logic              access_ok;
  logic              wr_en;
  logic              rd_en;
  logic              eoi_all;
  logic [31:0]       rdata;
  logic [CNT_W-1:0]  load_v [NUM_CH];
  logic [CNT_W-1:0]  cur_v  [NUM_CH];
  logic [CTRL_W-1:0] ctrl_v [NUM_CH];
  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] imask;
  logic              unused_bits;

  assign addr = {paddr[11:2], 2'b00};

`ifdef TIMN_SEC_CHK_EN
  // Trusted-only block: non-secure (pprot[1]) accesses are silently dropped; ETB inputs are unaffected.
  assign access_ok   = !(tipc_trust && pprot[1]);
  assign unused_bits = ^{paddr[1:0], pprot[2], pprot[0]};
`else
  assign access_ok   = 1'b1;
  assign unused_bits = ^{paddr[1:0], pprot, tipc_trust};
`endif

  assign wr_en   = psel && penable && pwrite && access_ok;
  assign rd_en   = psel && penable && !pwrite && access_ok;
  assign eoi_all = rd_en && (addr == GLB_EOI_ALL);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timn_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i        (pclk),
      .rst_i        (prst),
      .load_we_i    (wr_en && (addr == ch_addr(i, OFF_LOAD))),
      .load_wdata_i (pwdata[CNT_W-1:0]),
      .ctrl_we_i    (wr_en && (addr == ch_addr(i, OFF_CTRL))),
      .ctrl_wdata_i (pwdata[CTRL_W-1:0]),
      .eoi_clr_i    (eoi_all || (rd_en && (addr == ch_addr(i, OFF_EOI)))),
      .etb_on_i     (etb_trig_en_on[i]),
      .etb_off_i    (etb_trig_en_off[i]),
      .load_o       (load_v[i]),
      .cur_o        (cur_v[i]),
      .ctrl_o       (ctrl_v[i]),
      .raw_o        (raw[i]),
      .trig_o       (etb_trig[i])
    );
    assign imask[i] = ctrl_v[i][CTRL_IMASK];
  end

  assign intr = raw & ~imask;

  // EOI registers and anything unmapped fall through to the zero default.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == ch_addr(i, OFF_LOAD))  rdata = 32'(load_v[i]);
      if (addr == ch_addr(i, OFF_CUR))   rdata = 32'(cur_v[i]);
      if (addr == ch_addr(i, OFF_CTRL))  rdata = 32'(ctrl_v[i]);
      if (addr == ch_addr(i, OFF_ISTAT)) rdata = 32'(intr[i]);
    end
    if (addr == GLB_ISTAT_ALL) rdata = 32'(intr);
    if (addr == GLB_RAW_ALL)   rdata = 32'(raw);
  end

  assign prdata = (psel && access_ok) ? rdata : '0;

endmodule
